reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
//  Read-side engine for the register file / Reg32 bank. Reads a run of registers
//  and streams each word out on a valid/ready port: value, index, last flag.
//  Sits between the CPU register file's spare read port and the debug/trace
//  unit, for register dumps without stalling the pipeline.
//  Register file read port is combinational: rf_rdata is valid in the same
//  cycle that rf_raddr is presented.
// PARAMETERS
//  NUM_REGS  32  registers in the bank; index wraps modulo NUM_REGS
//  ADDR_W     5  index width, clog2(NUM_REGS)
//  DATA_W    32  register data width
// PORTS
//  clk         in   1         clock, rising edge
//  rst         in   1         reset, asynchronous, active-high
//  start       in   1         1-cycle request; sampled only in IDLE
//  first_addr  in   ADDR_W    first register index, sampled with start
//  count       in   ADDR_W+1  words to read, 0..NUM_REGS, sampled with start
//  abort       in   1         synchronous cancel
//  rf_raddr    out  ADDR_W    register file read address
//  rf_rdata    in   DATA_W    register file read data, same cycle
//  m_valid     out  1         output word valid
//  m_ready     in   1         consumer accepts the word
//  m_data      out  DATA_W    register value
//  m_addr      out  ADDR_W    index of m_data
//  m_last      out  1         m_data is the final word of the run
//  busy        out  1         high in READ or SEND
//  done        out  1         1-cycle pulse when a run completes or is aborted
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, remaining=0. All outputs 0, including rf_raddr,
//   m_valid, m_data, m_addr, m_last, busy and done. Async assert, sync release.
//  rf_raddr = idx register at all times, including in IDLE.
//  States: IDLE, READ, SEND.
//  IDLE: on start=1 with count!=0: idx<=first_addr, remaining<=count; go READ.
//   On start=1 with count=0: done=1 on the next cycle; stay IDLE.
//  READ (1 cycle): m_data<=rf_rdata, m_addr<=idx, m_valid<=1,
//   m_last<=(remaining==1), idx<=idx+1 wrapped, remaining<=remaining-1; go SEND.
//   Latency from start to the first m_valid is 2 cycles.
//  SEND: m_valid, m_data, m_addr and m_last hold stable until m_valid&&m_ready.
//   On handshake with m_last=1: m_valid<=0, m_last<=0, done<=1; go IDLE.
//   On handshake with m_last=0: load the next word from rf_rdata exactly as in
//   READ; stay in SEND. No bubble, so throughput is 1 word/cycle when m_ready=1.
//  Index wrap: idx is modulo NUM_REGS. With NUM_REGS a power of two this is the
//   natural ADDR_W overflow: NUM_REGS-1 -> 0.
//  count=NUM_REGS reads every register exactly once, starting at first_addr.
//  The block does not special-case r0. It forwards whatever rf_rdata returns.
//  rf_rdata is sampled only on READ entry or on a SEND handshake. A register
//   write landing after that sample is not reflected (snapshot per word).
//  start while busy: ignored, with no effect on the current run.
//  abort (any state but IDLE): next cycle m_valid=0, m_last=0, done=1, state
//   IDLE. A handshake in the same cycle as abort is void. abort beats start.
//  abort while IDLE: no effect, and no done pulse.
//  busy = (state!=IDLE). done is never high in the same cycle as m_valid.
// TESTING
//  1. rf[i]=i*0x11111111. start, first=0, count=4, m_ready=1 -> m_data 0x0,
//     0x11111111, 0x22222222, 0x33333333 on consecutive cycles; first at start+2;
//     m_last on the 4th word; done 1 cycle later.
//  2. first=30, count=4 -> m_addr 30,31,0,1 (wrap); count=32 -> 32 words,
//     every index once.
//  3. m_ready toggled 1/0 pseudo-randomly -> m_data and m_addr are stable while
//     stalled; no word is lost or duplicated; order is preserved.
//  4. count=0 -> done pulses once, m_valid stays 0, busy stays 0.
//  5. abort after the 2nd handshake of a count=8 run -> next cycle m_valid=0,
//     done=1, IDLE. A new start, first=5, count=1 -> one word, m_addr=5, m_last=1.
//  6. rst asserted mid-SEND -> all outputs 0 immediately (async). After release,
//     start during busy is ignored and the run completes with its original count.

Source files
------------

// File: rtl/reg_dump_reader.sv
// Register dump engine: walks a run of register indices through the register
// file's combinational read port and streams each value out on a valid/ready port.
module reg_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n, idx_inc;
    logic [ADDR_W:0]   remaining, remaining_n;
    logic              m_valid_n, m_last_n, done_n;
    logic [DATA_W-1:0] m_data_n;
    logic [ADDR_W-1:0] m_addr_n;
    logic              load_word;

    // Explicit wrap keeps the index correct even for a non-power-of-two bank.
    assign idx_inc  = (idx == LAST_IDX) ? '0 : idx + IDX_ONE;
    assign rf_raddr = idx;
    assign busy     = (state != IDLE);

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        remaining_n = remaining;
        m_valid_n   = m_valid;
        m_last_n    = m_last;
        m_data_n    = m_data;
        m_addr_n    = m_addr;
        done_n      = 1'b0;
        load_word   = 1'b0;

        if (state != IDLE && abort) begin
            state_n   = IDLE;
            m_valid_n = 1'b0;
            m_last_n  = 1'b0;
            done_n    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            idx_n       = first_addr;
                            remaining_n = count;
                            state_n     = READ;
                        end else begin
                            done_n = 1'b1;
                        end
                    end
                end
                READ: begin
                    load_word = 1'b1;
                    state_n   = SEND;
                end
                SEND: begin
                    if (m_valid && m_ready) begin
                        if (m_last) begin
                            m_valid_n = 1'b0;
                            m_last_n  = 1'b0;
                            done_n    = 1'b1;
                            state_n   = IDLE;
                        end else begin
                            load_word = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Each word is a snapshot of rf_rdata taken at the moment it is loaded.
        if (load_word) begin
            m_data_n    = rf_rdata;
            m_addr_n    = idx;
            m_valid_n   = 1'b1;
            m_last_n    = (remaining == CNT_ONE);
            idx_n       = idx_inc;
            remaining_n = remaining - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            remaining <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
            m_addr    <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            remaining <= remaining_n;
            m_valid   <= m_valid_n;
            m_last    <= m_last_n;
            m_data    <= m_data_n;
            m_addr    <= m_addr_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: directed run table, hand-written abort
// and reset sequences, and randomized runs against a queue-based reference model.
module tb_reg_dump_reader;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int BUDGET   = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W:0]   count;
    logic              abort;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rf [NUM_REGS];

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [ADDR_W-1:0] first;
        logic [ADDR_W:0]   cnt;
        bit                rnd_ready;
        bit                inject_start;
        int                exp_words;
        logic [ADDR_W-1:0] exp_first_addr;
        logic [ADDR_W-1:0] exp_last_addr;
    } run_vec_t;

    always #5 clk = ~clk;

    assign rf_rdata = rf[rf_raddr];

    reg_dump_reader #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_addr(first_addr),
        .count     (count),
        .abort     (abort),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_addr    (m_addr),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 64'(m_valid), 64'd0);
        checkOutput({tag, "_data"},  64'(m_data),  64'd0);
        checkOutput({tag, "_addr"},  64'(m_addr),  64'd0);
        checkOutput({tag, "_last"},  64'(m_last),  64'd0);
        checkOutput({tag, "_busy"},  64'(busy),    64'd0);
        checkOutput({tag, "_done"},  64'(done),    64'd0);
        checkOutput({tag, "_raddr"}, 64'(rf_raddr), 64'd0);
    endtask

    // One complete run: the model is simply the ordered list of (index mod NUM_REGS, rf[index]).
    task automatic applyStimulus(input logic [ADDR_W-1:0] first, input logic [ADDR_W:0] cnt,
                                 input bit rnd_ready, input bit inject_start,
                                 output int words, output logic [ADDR_W-1:0] a_first,
                                 output logic [ADDR_W-1:0] a_last);
        logic [DATA_W-1:0]   exp_data[$];
        logic [ADDR_W-1:0]   exp_addr[$];
        logic [NUM_REGS-1:0] seen;
        int                  cyc;
        bit                  hs;
        words   = 0;
        a_first = '0;
        a_last  = '0;
        seen    = '0;
        for (int k = 0; k < int'(cnt); k++) begin
            exp_addr.push_back(ADDR_W'((int'(first) + k) % NUM_REGS));
            exp_data.push_back(rf[(int'(first) + k) % NUM_REGS]);
        end

        start      = 1'b1;
        first_addr = first;
        count      = cnt;
        m_ready    = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        start = 1'b0;

        if (cnt == '0) begin
            checkOutput("zero_done",  64'(done),    64'd1);
            checkOutput("zero_valid", 64'(m_valid), 64'd0);
            checkOutput("zero_busy",  64'(busy),    64'd0);
            tick();
            checkOutput("zero_done_pulse", 64'(done),    64'd0);
            checkOutput("zero_valid2",     64'(m_valid), 64'd0);
            checkOutput("zero_busy2",      64'(busy),    64'd0);
            return;
        end

        checkOutput("read_valid", 64'(m_valid), 64'd0);
        checkOutput("read_busy",  64'(busy),    64'd1);
        tick();
        checkOutput("first_latency", 64'(m_valid), 64'd1);

        cyc = 0;
        while (exp_addr.size() > 0 && cyc < BUDGET) begin
            checkOutput("run_valid", 64'(m_valid), 64'd1);
            checkOutput("run_busy",  64'(busy),    64'd1);
            checkOutput("run_done",  64'(done),    64'd0);
            checkOutput("word_data", 64'(m_data),  64'(exp_data[0]));
            checkOutput("word_addr", 64'(m_addr),  64'(exp_addr[0]));
            checkOutput("word_last", 64'(m_last),  64'(exp_addr.size() == 1));
            if (inject_start && cyc == 2) begin
                start      = 1'b1;
                first_addr = 5'd9;
                count      = 6'd2;
            end else begin
                start = 1'b0;
            end
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            hs      = m_valid && m_ready;
            tick();
            cyc++;
            if (hs) begin
                if (words == 0) a_first = exp_addr[0];
                a_last = exp_addr[0];
                seen[exp_addr[0]] = 1'b1;
                void'(exp_addr.pop_front());
                void'(exp_data.pop_front());
                words++;
            end
        end
        start = 1'b0;

        checkOutput("run_timeout", 64'(exp_addr.size()), 64'd0);
        if (cnt == (ADDR_W+1)'(NUM_REGS))
            checkOutput("all_indices", 64'(seen), {{(64-NUM_REGS){1'b0}}, {NUM_REGS{1'b1}}});
        checkOutput("end_valid", 64'(m_valid), 64'd0);
        checkOutput("end_last",  64'(m_last),  64'd0);
        checkOutput("end_done",  64'(done),    64'd1);
        checkOutput("end_busy",  64'(busy),    64'd0);
        checkOutput("idle_raddr", 64'(rf_raddr), 64'((int'(first) + int'(cnt)) % NUM_REGS));
        tick();
        checkOutput("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        run_vec_t          vecs[$];
        int                words;
        logic [ADDR_W-1:0] a_first, a_last;
        logic [ADDR_W-1:0] rfirst;
        logic [ADDR_W:0]   rcnt;

        rst        = 1'b0;
        start      = 1'b0;
        first_addr = '0;
        count      = '0;
        abort      = 1'b0;
        m_ready    = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(i) * 32'h1111_1111;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // first, cnt, random ready, start-while-busy, words, first addr, last addr
        vecs.push_back('{5'd0,  6'd4,  1'b0, 1'b0, 4,  5'd0,  5'd3});
        vecs.push_back('{5'd30, 6'd4,  1'b0, 1'b0, 4,  5'd30, 5'd1});
        vecs.push_back('{5'd0,  6'd32, 1'b0, 1'b0, 32, 5'd0,  5'd31});
        vecs.push_back('{5'd17, 6'd32, 1'b1, 1'b0, 32, 5'd17, 5'd16});
        vecs.push_back('{5'd4,  6'd0,  1'b0, 1'b0, 0,  5'd0,  5'd0});
        vecs.push_back('{5'd31, 6'd1,  1'b1, 1'b0, 1,  5'd31, 5'd31});
        vecs.push_back('{5'd10, 6'd7,  1'b1, 1'b1, 7,  5'd10, 5'd16});

        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v].first, vecs[v].cnt, vecs[v].rnd_ready, vecs[v].inject_start,
                          words, a_first, a_last);
            checkOutput("tbl_words", 64'(words), 64'(vecs[v].exp_words));
            if (vecs[v].exp_words != 0) begin
                checkOutput("tbl_first_addr", 64'(a_first), 64'(vecs[v].exp_first_addr));
                checkOutput("tbl_last_addr",  64'(a_last),  64'(vecs[v].exp_last_addr));
            end
        end

        $display("[TB] abort after second handshake");
        start = 1'b1; first_addr = 5'd0; count = 6'd8; m_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("abort_w0_addr", 64'(m_addr), 64'd0);
        tick();
        tick();
        checkOutput("abort_w2_addr", 64'(m_addr),  64'd2);
        checkOutput("abort_w2_data", 64'(m_data),  64'h2222_2222);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_valid", 64'(m_valid), 64'd0);
        checkOutput("abort_last",  64'(m_last),  64'd0);
        checkOutput("abort_done",  64'(done),    64'd1);
        checkOutput("abort_busy",  64'(busy),    64'd0);
        checkOutput("abort_void_hs_raddr", 64'(rf_raddr), 64'd3);
        tick();
        checkOutput("abort_done_pulse", 64'(done), 64'd0);
        applyStimulus(5'd5, 6'd1, 1'b0, 1'b0, words, a_first, a_last);
        checkOutput("post_abort_words", 64'(words),   64'd1);
        checkOutput("post_abort_addr",  64'(a_first), 64'd5);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("idle_abort_done", 64'(done), 64'd0);
        checkOutput("idle_abort_busy", 64'(busy), 64'd0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
            rfirst = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            rcnt   = (ADDR_W+1)'($urandom_range(1, NUM_REGS));
            applyStimulus(rfirst, rcnt, 1'b1, 1'b0, words, a_first, a_last);
            checkOutput("rnd_words", 64'(words), 64'(rcnt));
        end

        $display("[TB] reset mid-SEND");
        start = 1'b1; first_addr = 5'd3; count = 6'd6; m_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        checkOutput("pre_reset_valid", 64'(m_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkAllZero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        applyStimulus(5'd20, 6'd5, 1'b1, 1'b1, words, a_first, a_last);
        checkOutput("post_reset_words", 64'(words),  64'd5);
        checkOutput("post_reset_last",  64'(a_last), 64'd24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
